pio_fifo: RTL and testbench
===========================

// Module: pio_fifo
// PURPOSE
//   CPU-side FIFO pair for one PIO state machine; the other end of the machine's push/pull strobes.
//   TX path: CPU writes words, the machine consumes them with 'pull'.
//   RX path: the machine produces words with 'push', the CPU reads them.
//   Optional join merges both storage halves into one deeper FIFO. Sticky debug flags record every lost transfer.
// PARAMETERS
//   WIDTH  32  data word width
//   DEPTH  4   entries per direction; power of 2, >=2. Joined direction gets 2*DEPTH.
// PORTS
//   clk           in   1        system clock; all state updates on posedge
//   reset         in   1        synchronous, active-high
//   join_tx       in   1        1: TX uses 2*DEPTH entries, RX disabled
//   join_rx       in   1        1: RX uses 2*DEPTH entries, TX disabled; ignored while join_tx=1
//   cpu_wr        in   1        push cpu_wdata into TX FIFO
//   cpu_wdata     in   WIDTH    TX write data
//   cpu_rd        in   1        pop RX FIFO head
//   cpu_rdata     out  WIDTH    RX head (first-word fall-through); 0 when RX empty
//   sm_pull       in   1        machine pop of TX head (one-cycle strobe)
//   sm_pull_data  out  WIDTH    TX head (fall-through); 0 when TX empty
//   sm_push       in   1        machine push of sm_push_data into RX (one-cycle strobe)
//   sm_push_data  in   WIDTH    RX write data
//   tx_full       out  1        TX level == TX capacity
//   tx_empty      out  1        TX level == 0
//   rx_full       out  1        RX level == RX capacity
//   rx_empty      out  1        RX level == 0
//   tx_level      out  L        L=$clog2(DEPTH)+2; entries held in TX
//   rx_level      out  L        entries held in RX
//   fdebug        out  4        sticky {txstall, txover, rxunder, rxstall}
//   fdebug_clr    in   4        write-1-to-clear per fdebug bit
// BEHAVIOUR
//   - Reset: both FIFOs empty, read/write pointers 0, levels 0, fdebug=0.
//     sm_pull_data=0, cpu_rdata=0, tx_empty=rx_empty=1, tx_full=rx_full=0.
//   - Capacity: unjoined TX=RX=DEPTH. join_tx: TX=2*DEPTH, RX=0.
//     join_rx (join_tx=0): RX=2*DEPTH, TX=0. A direction with capacity 0 reads full=1, empty=1, level=0.
//   - Join change: join_tx/join_rx registered internally. Any change from the previous cycle flushes both FIFOs
//     (pointers and levels to 0) on that edge; all transfers in that cycle are discarded. fdebug is not affected.
//   - Data storage: circular buffer of 2*DEPTH words. Unjoined: TX owns entries [0,DEPTH), RX owns [DEPTH,2*DEPTH).
//     Joined: one direction owns all entries. Pointers wrap modulo capacity.
//   - Write latency: a word written at edge N is visible on the head output after edge N.
//     There is no same-cycle bypass from write data to head.
//   - TX write: cpu_wr with !tx_full stores the word and increments level.
//     cpu_wr with tx_full drops the word and sets txover (except under the simultaneous rule below).
//   - TX pull: sm_pull with !tx_empty pops the head.
//     sm_pull with tx_empty pops nothing and sets txstall.
//   - Simultaneous TX write+pull:
//       * full: both succeed, level unchanged, no flag.
//       * empty: write succeeds, pull fails and sets txstall.
//       * otherwise: both succeed, level unchanged.
//   - RX: symmetric to TX with push/rd in place of wr/pull.
//     Push when full drops the word and sets rxstall. cpu_rd when empty sets rxunder.
//     Full with push+rd: both succeed. Empty with push+rd: push succeeds, rd fails and sets rxunder.
//   - Disabled direction (capacity 0): every access fails and sets its flag.
//   - fdebug: a bit set by an event and cleared by fdebug_clr in the same cycle ends set (set wins).
//   - Level arithmetic is exact; a level never exceeds capacity and never underflows.
// TESTING
//   1. Reset, write A,B,C,D via cpu_wr -> tx_full=1, tx_level=4, sm_pull_data=A; 4 pulls yield A,B,C,D, then tx_empty=1.
//   2. TX full + cpu_wr E alone -> E dropped, fdebug[2]=1; fdebug_clr=4'b0100 -> fdebug=0.
//      TX full + cpu_wr+sm_pull together -> level stays 4, new tail=E.
//   3. Empty RX, sm_push X with cpu_rd same cycle -> rx_level=1, fdebug[1]=1; next cycle cpu_rdata=X.
//   4. join_tx=1, write 8 words 1..8 -> tx_full only after 8th write; rx_full=rx_empty=1; sm_push sets fdebug[0].
//      Pulls return 1..8 in order across the pointer wrap.
//   5. TX holding 3 words, toggle join_rx 0->1 -> next cycle tx_level=0, rx_level=0, rx capacity 8.
//   6. Mid-operation reset with both FIFOs half full and pending strobes -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/pio_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pio_fifo                                                        |
// | Brief  : CPU-side TX/RX FIFO pair for one PIO machine, joinable storage. |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module pio_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       join_tx,
    input  logic                       join_rx,
    input  logic                       cpu_wr,
    input  logic [WIDTH-1:0]           cpu_wdata,
    input  logic                       cpu_rd,
    output logic [WIDTH-1:0]           cpu_rdata,
    input  logic                       sm_pull,
    output logic [WIDTH-1:0]           sm_pull_data,
    input  logic                       sm_push,
    input  logic [WIDTH-1:0]           sm_push_data,
    output logic                       tx_full,
    output logic                       tx_empty,
    output logic                       rx_full,
    output logic                       rx_empty,
    output logic [$clog2(DEPTH)+1:0]   tx_level,
    output logic [$clog2(DEPTH)+1:0]   rx_level,
    output logic [3:0]                 fdebug,
    input  logic [3:0]                 fdebug_clr
);

    localparam int L  = $clog2(DEPTH) + 2;
    localparam int PW = $clog2(2 * DEPTH);
    localparam logic [L-1:0]  C_CAP1    = L'(DEPTH);
    localparam logic [L-1:0]  C_CAP2    = L'(2 * DEPTH);
    localparam logic [PW-1:0] C_RX_BASE = PW'(DEPTH);

    logic [WIDTH-1:0] r_mem [2*DEPTH];
    logic             r_join_tx, r_join_rx;
    logic [PW-1:0]    r_tx_rd, r_tx_wr, r_rx_rd, r_rx_wr;
    logic [L-1:0]     r_tx_level, r_rx_level;
    logic [3:0]       r_fdebug;

    logic             w_mode_tx, w_mode_rx, w_flush;
    logic [L-1:0]     w_tx_cap, w_rx_cap;
    logic [PW-1:0]    w_rx_base, w_rx_rd_addr, w_rx_wr_addr;
    logic             w_tx_wr_ok, w_tx_pull_ok, w_rx_push_ok, w_rx_rd_ok;
    logic [3:0]       w_fd_set;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p, input logic [L-1:0] cap);
        return (({1'b0, p} + L'(1)) == cap) ? '0 : p + PW'(1);
    endfunction

    // Capacity follows the registered mode, which changes on the same edge that flushes the levels.
    assign w_mode_tx = r_join_tx;
    assign w_mode_rx = r_join_rx & ~r_join_tx;
    assign w_tx_cap  = w_mode_tx ? C_CAP2 : (w_mode_rx ? '0 : C_CAP1);
    assign w_rx_cap  = w_mode_tx ? '0 : (w_mode_rx ? C_CAP2 : C_CAP1);
    assign w_rx_base = w_mode_rx ? '0 : C_RX_BASE;
    assign w_flush   = (join_tx != r_join_tx) || (join_rx != r_join_rx);

    assign w_rx_rd_addr = w_rx_base + r_rx_rd;
    assign w_rx_wr_addr = w_rx_base + r_rx_wr;

    assign tx_level = r_tx_level;
    assign rx_level = r_rx_level;
    assign tx_full  = (r_tx_level == w_tx_cap);
    assign rx_full  = (r_rx_level == w_rx_cap);
    assign tx_empty = (r_tx_level == '0);
    assign rx_empty = (r_rx_level == '0);
    assign fdebug   = r_fdebug;

    assign sm_pull_data = tx_empty ? '0 : r_mem[r_tx_rd];
    assign cpu_rdata    = rx_empty ? '0 : r_mem[w_rx_rd_addr];

    // A full, enabled FIFO is never empty, so a concurrent pop always makes room for the write.
    assign w_tx_pull_ok = sm_pull && !tx_empty;
    assign w_tx_wr_ok   = cpu_wr && (w_tx_cap != '0) && (!tx_full || sm_pull);
    assign w_rx_rd_ok   = cpu_rd && !rx_empty;
    assign w_rx_push_ok = sm_push && (w_rx_cap != '0) && (!rx_full || cpu_rd);

    assign w_fd_set = w_flush ? 4'b0000 :
                      {sm_pull && !w_tx_pull_ok, cpu_wr && !w_tx_wr_ok,
                       cpu_rd && !w_rx_rd_ok,    sm_push && !w_rx_push_ok};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_join_tx  <= 1'b0;
            r_join_rx  <= 1'b0;
            r_tx_rd    <= '0;
            r_tx_wr    <= '0;
            r_rx_rd    <= '0;
            r_rx_wr    <= '0;
            r_tx_level <= '0;
            r_rx_level <= '0;
            r_fdebug   <= '0;
        end else begin
            r_join_tx <= join_tx;
            r_join_rx <= join_rx;
            r_fdebug  <= (r_fdebug & ~fdebug_clr) | w_fd_set;
            if (w_flush) begin
                r_tx_rd    <= '0;
                r_tx_wr    <= '0;
                r_rx_rd    <= '0;
                r_rx_wr    <= '0;
                r_tx_level <= '0;
                r_rx_level <= '0;
            end else begin
                if (w_tx_wr_ok)   r_tx_wr <= ptr_inc(r_tx_wr, w_tx_cap);
                if (w_tx_pull_ok) r_tx_rd <= ptr_inc(r_tx_rd, w_tx_cap);
                if (w_rx_push_ok) r_rx_wr <= ptr_inc(r_rx_wr, w_rx_cap);
                if (w_rx_rd_ok)   r_rx_rd <= ptr_inc(r_rx_rd, w_rx_cap);
                r_tx_level <= r_tx_level + L'(w_tx_wr_ok) - L'(w_tx_pull_ok);
                r_rx_level <= r_rx_level + L'(w_rx_push_ok) - L'(w_rx_rd_ok);
            end
        end
    end

    // Storage needs no reset: heads are masked to zero whenever a direction is empty.
    always_ff @(posedge clk) begin
        if (!reset && !w_flush) begin
            if (w_tx_wr_ok)   r_mem[r_tx_wr]      <= cpu_wdata;
            if (w_rx_push_ok) r_mem[w_rx_wr_addr] <= sm_push_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_fifo.sv
`default_nettype none
// Testbench for pio_fifo: table of directed vectors plus hand-written join/flush/reset sequences.
module tb_pio_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        join_tx, join_rx;
    logic        cpu_wr, cpu_rd, sm_pull, sm_push;
    logic [31:0] cpu_wdata, sm_push_data, cpu_rdata, sm_pull_data;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [3:0]  tx_level, rx_level, fdebug, fdebug_clr;

    int total = 0;
    int bad   = 0;

    pio_fifo #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .join_tx(join_tx), .join_rx(join_rx),
        .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata),
        .sm_pull(sm_pull), .sm_pull_data(sm_pull_data), .sm_push(sm_push),
        .sm_push_data(sm_push_data), .tx_full(tx_full), .tx_empty(tx_empty),
        .rx_full(rx_full), .rx_empty(rx_empty), .tx_level(tx_level), .rx_level(rx_level),
        .fdebug(fdebug), .fdebug_clr(fdebug_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] wdata;
        logic        pull;
        logic        push;
        logic [31:0] pdata;
        logic        rd;
        logic [3:0]  clr;
        logic [3:0]  e_txl;
        logic [3:0]  e_rxl;
        logic [31:0] e_pd;
        logic [31:0] e_rdt;
        logic [3:0]  e_fd;
        logic [3:0]  e_flags;   // {tx_full, tx_empty, rx_full, rx_empty}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [31:0] wd, logic pull, logic push, logic [31:0] pd,
                                logic rd, logic [3:0] clr, logic [3:0] txl, logic [3:0] rxl,
                                logic [31:0] epd, logic [31:0] erd, logic [3:0] fd, logic [3:0] fl);
        vec_t v;
        v.wr = wr; v.wdata = wd; v.pull = pull; v.push = push; v.pdata = pd; v.rd = rd; v.clr = clr;
        v.e_txl = txl; v.e_rxl = rxl; v.e_pd = epd; v.e_rdt = erd; v.e_fd = fd; v.e_flags = fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] txl, input logic [3:0] rxl,
                             input logic [31:0] pd, input logic [31:0] rdt,
                             input logic [3:0] fd, input logic [3:0] fl);
        check({tag, ".tx_level"}, 32'(tx_level), 32'(txl));
        check({tag, ".rx_level"}, 32'(rx_level), 32'(rxl));
        check({tag, ".pull_data"}, sm_pull_data, pd);
        check({tag, ".cpu_rdata"}, cpu_rdata, rdt);
        check({tag, ".fdebug"}, 32'(fdebug), 32'(fd));
        check({tag, ".flags"}, 32'({tx_full, tx_empty, rx_full, rx_empty}), 32'(fl));
    endtask

    task automatic step(input logic wr, input logic [31:0] wd, input logic pull, input logic push,
                        input logic [31:0] pd, input logic rd, input logic [3:0] clr);
        cpu_wr = wr; cpu_wdata = wd; sm_pull = pull; sm_push = push;
        sm_push_data = pd; cpu_rd = rd; fdebug_clr = clr;
        @(posedge clk);
        #1;
        cpu_wr = 0; sm_pull = 0; sm_push = 0; cpu_rd = 0; fdebug_clr = 0;
    endtask

    initial begin
        reset = 1; join_tx = 0; join_rx = 0;
        cpu_wr = 0; cpu_rd = 0; sm_pull = 0; sm_push = 0;
        cpu_wdata = 0; sm_push_data = 0; fdebug_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 4'b0000, 4'b0101);
        reset = 0;

        //            wr wdata  pl ps pdata  rd clr      txl rxl pd     rdt    fd       flags
        vecs.push_back(mk(1, 32'hA, 0, 0, 0,     0, 4'h0,  1, 0, 32'hA, 0,     4'b0000, 4'b0001));
        vecs.push_back(mk(1, 32'hB, 0, 0, 0,     0, 4'h0,  2, 0, 32'hA, 0,     4'b0000, 4'b0001));
        vecs.push_back(mk(1, 32'hC, 0, 0, 0,     0, 4'h0,  3, 0, 32'hA, 0,     4'b0000, 4'b0001));
        vecs.push_back(mk(1, 32'hD, 0, 0, 0,     0, 4'h0,  4, 0, 32'hA, 0,     4'b0000, 4'b1001));
        vecs.push_back(mk(0, 0,     1, 0, 0,     0, 4'h0,  3, 0, 32'hB, 0,     4'b0000, 4'b0001));
        vecs.push_back(mk(0, 0,     1, 0, 0,     0, 4'h0,  2, 0, 32'hC, 0,     4'b0000, 4'b0001));
        vecs.push_back(mk(0, 0,     1, 0, 0,     0, 4'h0,  1, 0, 32'hD, 0,     4'b0000, 4'b0001));
        vecs.push_back(mk(0, 0,     1, 0, 0,     0, 4'h0,  0, 0, 0,     0,     4'b0000, 4'b0101));
        vecs.push_back(mk(1, 32'h11,0, 0, 0,     0, 4'h0,  1, 0, 32'h11,0,     4'b0000, 4'b0001));
        vecs.push_back(mk(1, 32'h12,0, 0, 0,     0, 4'h0,  2, 0, 32'h11,0,     4'b0000, 4'b0001));
        vecs.push_back(mk(1, 32'h13,0, 0, 0,     0, 4'h0,  3, 0, 32'h11,0,     4'b0000, 4'b0001));
        vecs.push_back(mk(1, 32'h14,0, 0, 0,     0, 4'h0,  4, 0, 32'h11,0,     4'b0000, 4'b1001));
        vecs.push_back(mk(1, 32'hE, 0, 0, 0,     0, 4'h0,  4, 0, 32'h11,0,     4'b0100, 4'b1001));
        vecs.push_back(mk(0, 0,     0, 0, 0,     0, 4'h4,  4, 0, 32'h11,0,     4'b0000, 4'b1001));
        vecs.push_back(mk(1, 32'hE, 1, 0, 0,     0, 4'h0,  4, 0, 32'h12,0,     4'b0000, 4'b1001));
        vecs.push_back(mk(0, 0,     1, 0, 0,     0, 4'h0,  3, 0, 32'h13,0,     4'b0000, 4'b0001));
        vecs.push_back(mk(0, 0,     1, 0, 0,     0, 4'h0,  2, 0, 32'h14,0,     4'b0000, 4'b0001));
        vecs.push_back(mk(0, 0,     1, 0, 0,     0, 4'h0,  1, 0, 32'hE, 0,     4'b0000, 4'b0001));
        vecs.push_back(mk(0, 0,     1, 0, 0,     0, 4'h0,  0, 0, 0,     0,     4'b0000, 4'b0101));
        vecs.push_back(mk(0, 0,     1, 0, 0,     0, 4'h0,  0, 0, 0,     0,     4'b1000, 4'b0101));
        vecs.push_back(mk(0, 0,     1, 0, 0,     0, 4'h8,  0, 0, 0,     0,     4'b1000, 4'b0101));
        vecs.push_back(mk(0, 0,     0, 0, 0,     0, 4'h8,  0, 0, 0,     0,     4'b0000, 4'b0101));
        vecs.push_back(mk(0, 0,     0, 1, 32'h55,1, 4'h0,  0, 1, 0,     32'h55,4'b0010, 4'b0100));
        vecs.push_back(mk(0, 0,     0, 1, 32'h66,0, 4'h0,  0, 2, 0,     32'h55,4'b0010, 4'b0100));
        vecs.push_back(mk(0, 0,     0, 0, 0,     1, 4'h0,  0, 1, 0,     32'h66,4'b0010, 4'b0100));
        vecs.push_back(mk(0, 0,     0, 1, 32'h77,0, 4'h0,  0, 2, 0,     32'h66,4'b0010, 4'b0100));
        vecs.push_back(mk(0, 0,     0, 1, 32'h88,0, 4'h0,  0, 3, 0,     32'h66,4'b0010, 4'b0100));
        vecs.push_back(mk(0, 0,     0, 1, 32'h99,0, 4'h0,  0, 4, 0,     32'h66,4'b0010, 4'b0110));
        vecs.push_back(mk(0, 0,     0, 1, 32'hAA,0, 4'h0,  0, 4, 0,     32'h66,4'b0011, 4'b0110));
        vecs.push_back(mk(0, 0,     0, 1, 32'hBB,1, 4'h0,  0, 4, 0,     32'h77,4'b0011, 4'b0110));
        vecs.push_back(mk(0, 0,     0, 0, 0,     0, 4'hF,  0, 4, 0,     32'h77,4'b0000, 4'b0110));

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].wdata, vecs[i].pull, vecs[i].push, vecs[i].pdata,
                 vecs[i].rd, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].e_txl, vecs[i].e_rxl, vecs[i].e_pd,
                      vecs[i].e_rdt, vecs[i].e_fd, vecs[i].e_flags);
        end

        // Joined TX: flush discards the concurrent write and the 4 RX words.
        join_tx = 1;
        step(1, 32'hDEAD, 0, 0, 0, 0, 4'h0);
        check_all("jtx_flush", 0, 0, 0, 0, 4'b0000, 4'b0111);
        for (int k = 1; k <= 8; k++) begin
            step(1, 32'(k), 0, 0, 0, 0, 4'h0);
            check_all($sformatf("jtx_wr%0d", k), 4'(k), 0, 1, 0, 4'b0000, {k == 8, 1'b0, 1'b1, 1'b1});
        end
        step(0, 0, 0, 1, 32'h5, 1, 4'h0);
        check_all("jtx_rx_dis", 8, 0, 1, 0, 4'b0011, 4'b1011);
        step(1, 32'h9, 0, 0, 0, 0, 4'h0);
        check_all("jtx_over", 8, 0, 1, 0, 4'b0111, 4'b1011);
        step(0, 0, 0, 0, 0, 0, 4'h7);
        step(0, 0, 1, 0, 0, 0, 4'h0);
        step(0, 0, 1, 0, 0, 0, 4'h0);
        check_all("jtx_pull2", 6, 0, 3, 0, 4'b0000, 4'b0011);
        step(1, 32'h9, 0, 0, 0, 0, 4'h0);
        step(1, 32'hA, 0, 0, 0, 0, 4'h0);
        check_all("jtx_wrap", 8, 0, 3, 0, 4'b0000, 4'b1011);
        for (int j = 1; j <= 8; j++) begin
            step(0, 0, 1, 0, 0, 0, 4'h0);
            check_all($sformatf("jtx_pull%0d", j), 4'(8 - j), 0, (j < 8) ? 32'(3 + j) : 32'h0, 0,
                      4'b0000, {1'b0, j == 8, 1'b1, 1'b1});
        end

        // Back to unjoined, fill TX with 3, then join RX.
        join_tx = 0;
        step(0, 0, 0, 0, 0, 0, 4'h0);
        check_all("unjoin", 0, 0, 0, 0, 4'b0000, 4'b0101);
        for (int k = 1; k <= 3; k++) step(1, 32'h30 + 32'(k), 0, 0, 0, 0, 4'h0);
        check_all("tx3", 3, 0, 32'h31, 0, 4'b0000, 4'b0001);
        join_rx = 1;
        step(1, 32'h34, 0, 0, 0, 0, 4'h0);
        check_all("jrx_flush", 0, 0, 0, 0, 4'b0000, 4'b1101);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0, 1, 32'h40 + 32'(k), 0, 4'h0);
            check_all($sformatf("jrx_push%0d", k), 0, 4'(k), 0, 32'h41, 4'b0000,
                      {1'b1, 1'b1, k == 8, 1'b0});
        end
        step(1, 32'h99, 0, 0, 0, 0, 4'h0);
        check_all("jrx_tx_dis", 0, 8, 0, 32'h41, 4'b0100, 4'b1110);
        for (int j = 1; j <= 8; j++) begin
            step(0, 0, 0, 0, 0, 1, 4'h0);
            check_all($sformatf("jrx_rd%0d", j), 0, 4'(8 - j), 0, (j < 8) ? 32'h41 + 32'(j) : 32'h0,
                      4'b0100, {1'b1, 1'b1, 1'b0, j == 8});
        end

        // Flush leaves fdebug alone; then reset mid-operation with strobes pending.
        join_rx = 0;
        step(0, 0, 0, 0, 0, 0, 4'h0);
        check_all("unjoin_rx", 0, 0, 0, 0, 4'b0100, 4'b0101);
        step(1, 32'h61, 0, 1, 32'h71, 0, 4'h0);
        step(1, 32'h62, 0, 1, 32'h72, 0, 4'h0);
        check_all("half", 2, 2, 32'h61, 32'h71, 4'b0100, 4'b0000);
        reset = 1;
        step(1, 32'h63, 1, 1, 32'h73, 1, 4'h0);
        check_all("mid_reset", 0, 0, 0, 0, 4'b0000, 4'b0101);
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
